// File: rtl/fifo_wr_ctrl.sv
// Write-side control of the async FIFO: write pointer, memory write port, read-pointer sync, full/level.
// Optional sticky overflow flag (ports ovf_clr/overflow) is built when FIFO_WR_OVERFLOW_FLAG_EN is defined.
module fifo_wr_ctrl #(
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH-1:0] rptr_gray,
`ifdef FIFO_WR_OVERFLOW_FLAG_EN
  input  logic                  ovf_clr,
  output logic                  overflow,
`endif
  output logic [ADDR_WIDTH-2:0] waddr,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH-1:0] wlevel
);

  localparam logic [ADDR_WIDTH-1:0] FULL_MASK = ADDR_WIDTH'(3) << (ADDR_WIDTH - 2);
  localparam logic [ADDR_WIDTH-1:0] AFULL_LVL = ADDR_WIDTH'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LVL = ADDR_WIDTH'(FIFO_DEPTH);

  function automatic logic [ADDR_WIDTH-1:0] bin2gray(input logic [ADDR_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] gray2bin(input logic [ADDR_WIDTH-1:0] g);
    logic [ADDR_WIDTH-1:0] b;
    b[ADDR_WIDTH-1] = g[ADDR_WIDTH-1];
    for (int i = ADDR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_WIDTH-1:0] wptr_bin;
  logic [ADDR_WIDTH-1:0] wptr_bin_nxt;
  logic [ADDR_WIDTH-1:0] rq_sync_p [SYNC_STAGES];
  logic [ADDR_WIDTH-1:0] rq_sync;
  logic [ADDR_WIDTH-1:0] rq_bin;

  assign wclken       = winc & ~full;
  assign wptr_bin_nxt = wptr_bin + ADDR_WIDTH'(1);
  assign waddr        = wptr_bin[ADDR_WIDTH-2:0];

  // Pointer stage: binary and Gray copies advance together so wptr_gray is always a flop output.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_bin  <= '0;
      wptr_gray <= '0;
    end else if (wclken) begin
      wptr_bin  <= wptr_bin_nxt;
      wptr_gray <= bin2gray(wptr_bin_nxt);
    end
  end

  // Synchroniser stage: the raw read pointer only ever feeds the first flop of this chain.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rq_sync_p[i] <= '0;
      end
    end else begin
      rq_sync_p[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rq_sync_p[i] <= rq_sync_p[i-1];
      end
    end
  end

  assign rq_sync = rq_sync_p[SYNC_STAGES-1];
  assign rq_bin  = gray2bin(rq_sync);

  // Status: full compares Gray pointers directly; a stale rq_sync can only overstate occupancy.
  assign full        = (wptr_gray == (rq_sync ^ FULL_MASK));
  assign wlevel      = wptr_bin - rq_bin;
  assign almost_full = (wlevel >= AFULL_LVL) && (AFULL_LVL <= DEPTH_LVL);

`ifdef FIFO_WR_OVERFLOW_FLAG_EN
  // A dropped write in the same edge as a clear keeps the flag set.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      overflow <= 1'b0;
    end else if (winc && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end
`endif

endmodule
